basic_shit_cpu_jtag_ocimem: RTL and testbench



---
 rtl/basic_shit_cpu_jtag_ocimem_pkg.sv | 18 +
 rtl/basic_shit_cpu_jtag_ocimem_if.sv | 32 +++
 rtl/basic_shit_cpu_jtag_ocimem_ram.sv | 35 +++
 rtl/basic_shit_cpu_jtag_ocimem.sv | 177 +++++++++++++++++
 tb/tb_basic_shit_cpu_jtag_ocimem.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/basic_shit_cpu_jtag_ocimem_pkg.sv
// Shared types and jdo field positions for the JTAG on-chip monitor memory.
package basic_shit_ocimem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_J_RD,
    ST_J_WR,
    ST_C_RD
  } ocimem_state_e;

  localparam int DEF_ADDR_W   = 8;
  localparam int JDO_RD       = 35;
  localparam int JDO_ADDR_LSB = 26;
  localparam int JDO_ERRCLR   = 25;
  localparam int JDO_DATA_MSB = 34;
  localparam int JDO_DATA_LSB = 3;

endpackage

// File: rtl/basic_shit_cpu_jtag_ocimem_if.sv
// JTAG strobe/jdo side plus CPU debug-slave Avalon side of the monitor memory.
interface basic_shit_cpu_jtag_ocimem_if #(
  parameter int ADDR_W = basic_shit_ocimem_pkg::DEF_ADDR_W
);
  logic [37:0]       jdo;
  logic              take_action_ocimem_a;
  logic              take_action_ocimem_b;
  logic              take_no_action_ocimem_a;
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [3:0]        byteenable;
  logic              debugaccess;
  logic [31:0]       readdata;
  logic              waitrequest;
  logic [31:0]       MonDReg;
  logic              monitor_ready;
  logic              monitor_error;

  modport master (
    output jdo, take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
    output address, read, write, writedata, byteenable, debugaccess,
    input  readdata, waitrequest, MonDReg, monitor_ready, monitor_error
  );

  modport slave (
    input  jdo, take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
    input  address, read, write, writedata, byteenable, debugaccess,
    output readdata, waitrequest, MonDReg, monitor_ready, monitor_error
  );
endinterface

// File: rtl/basic_shit_cpu_jtag_ocimem_ram.sv
// Single-port synchronous RAM, four byte lanes of LANE_W bits, 1-cycle read latency.
module basic_shit_cpu_ocimem_ram #(
  parameter int ADDR_W = 8,
  parameter int LANE_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_we,
  input  logic                i_re,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [4*LANE_W-1:0] i_wdata,
  input  logic [3:0]          i_be,
  output logic [4*LANE_W-1:0] o_rdata
);

  logic [4*LANE_W-1:0] r_mem [2**ADDR_W];
  logic [4*LANE_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = 0; i < 4; i++) begin
        if (i_be[i]) r_mem[i_addr][i*LANE_W +: LANE_W] <= i_wdata[i*LANE_W +: LANE_W];
      end
    end
  end

  // The read register clears on reset so a pending read cannot leak data afterwards.
  always_ff @(posedge clk) begin
    if (reset)     r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/basic_shit_cpu_jtag_ocimem.sv
// JTAG/CPU shared monitor RAM with MonAReg/MonDReg handshake.
// OCIMEM_PARITY_EN adds an even-parity bit per byte and reports read mismatches on monitor_error.
module basic_shit_cpu_jtag_ocimem
  import basic_shit_ocimem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = 32
) (
  input logic                         clk,
  input logic                         reset,
  basic_shit_cpu_jtag_ocimem_if.slave bus
);

`ifdef OCIMEM_PARITY_EN
  localparam int LANE_W = 9;
`else
  localparam int LANE_W = 8;
`endif

  ocimem_state_e       r_state, w_stateNxt;
  logic [ADDR_W-1:0]   r_monAReg, w_aRegNxt;
  logic [DATA_W-1:0]   r_monDReg, w_dRegNxt;
  logic                r_ready, w_readyNxt;
  logic                r_error, w_errorNxt;
  logic                r_postInc, w_postIncNxt;
  logic                r_rdPhase, w_rdPhaseNxt;

  logic                w_ramWe, w_ramRe, w_wait, w_parErr;
  logic [ADDR_W-1:0]   w_ramAddr;
  logic [31:0]         w_ramWdata, w_ramData;
  logic [3:0]          w_ramBe;
  logic [4*LANE_W-1:0] w_ramWide, w_ramRaw;
  logic                w_strA, w_strB, w_strN, w_anyStrobe, w_multi;

  assign w_strA      = bus.take_action_ocimem_a;
  assign w_strB      = bus.take_action_ocimem_b;
  assign w_strN      = bus.take_no_action_ocimem_a;
  assign w_anyStrobe = w_strA | w_strB | w_strN;
  assign w_multi     = (w_strA & w_strB) | (w_strA & w_strN) | (w_strB & w_strN);

  always_comb begin
    w_ramWide = '0;
    w_ramData = '0;
    w_parErr  = 1'b0;
`ifdef OCIMEM_PARITY_EN
    for (int i = 0; i < 4; i++) begin
      w_ramWide[i*9 +: 9] = {^w_ramWdata[i*8 +: 8], w_ramWdata[i*8 +: 8]};
      w_ramData[i*8 +: 8] = w_ramRaw[i*9 +: 8];
      w_parErr = w_parErr | (w_ramRaw[i*9+8] ^ (^w_ramRaw[i*9 +: 8]));
    end
`else
    w_ramWide = w_ramWdata;
    w_ramData = w_ramRaw;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_monAReg <= '0;
      r_monDReg <= '0;
      r_ready   <= 1'b0;
      r_error   <= 1'b0;
      r_postInc <= 1'b0;
      r_rdPhase <= 1'b0;
    end else begin
      r_state   <= w_stateNxt;
      r_monAReg <= w_aRegNxt;
      r_monDReg <= w_dRegNxt;
      r_ready   <= w_readyNxt;
      r_error   <= w_errorNxt;
      r_postInc <= w_postIncNxt;
      r_rdPhase <= w_rdPhaseNxt;
    end
  end

  // JTAG strobes outrank the CPU; J_RD spends one cycle issuing the read and one capturing it.
  always_comb begin
    w_stateNxt   = r_state;
    w_aRegNxt    = r_monAReg;
    w_dRegNxt    = r_monDReg;
    w_readyNxt   = r_ready;
    w_errorNxt   = r_error;
    w_postIncNxt = r_postInc;
    w_rdPhaseNxt = 1'b0;
    w_ramWe      = 1'b0;
    w_ramRe      = 1'b0;
    w_ramAddr    = r_monAReg;
    w_ramWdata   = r_monDReg;
    w_ramBe      = 4'hF;
    w_wait       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_strB) begin
          w_dRegNxt  = bus.jdo[JDO_DATA_MSB:JDO_DATA_LSB];
          w_stateNxt = ST_J_WR;
        end else if (w_strA) begin
          w_aRegNxt = bus.jdo[JDO_ADDR_LSB +: ADDR_W];
          if (bus.jdo[JDO_ERRCLR]) w_errorNxt = 1'b0;
          if (bus.jdo[JDO_RD]) begin
            w_readyNxt   = 1'b0;
            w_postIncNxt = 1'b0;
            w_stateNxt   = ST_J_RD;
          end
        end else if (w_strN) begin
          w_readyNxt   = 1'b0;
          w_postIncNxt = 1'b1;
          w_stateNxt   = ST_J_RD;
        end else if (bus.write) begin
          if (bus.debugaccess) begin
            w_ramWe    = 1'b1;
            w_ramAddr  = bus.address;
            w_ramWdata = bus.writedata;
            w_ramBe    = bus.byteenable;
          end else begin
            w_errorNxt = 1'b1;
          end
        end else if (bus.read) begin
          w_ramRe    = 1'b1;
          w_ramAddr  = bus.address;
          w_wait     = 1'b1;
          w_stateNxt = ST_C_RD;
        end
        if (w_anyStrobe & (bus.read | bus.write)) w_wait = 1'b1;
        if (w_multi) w_errorNxt = 1'b1;
      end
      ST_J_RD: begin
        w_wait = bus.read | bus.write;
        if (!r_rdPhase) begin
          w_ramRe      = 1'b1;
          w_rdPhaseNxt = 1'b1;
        end else begin
          w_dRegNxt  = w_ramData;
          w_readyNxt = 1'b1;
          if (r_postInc) w_aRegNxt = r_monAReg + 1'b1;
          if (w_parErr) w_errorNxt = 1'b1;
          w_stateNxt = ST_IDLE;
        end
        if (w_anyStrobe) w_errorNxt = 1'b1;
      end
      ST_J_WR: begin
        w_wait     = bus.read | bus.write;
        w_ramWe    = 1'b1;
        w_aRegNxt  = r_monAReg + 1'b1;
        w_stateNxt = ST_IDLE;
        if (w_anyStrobe) w_errorNxt = 1'b1;
      end
      ST_C_RD: begin
        w_wait     = bus.write;
        w_stateNxt = ST_IDLE;
        if (w_parErr | w_anyStrobe) w_errorNxt = 1'b1;
      end
      default: w_stateNxt = ST_IDLE;
    endcase
  end

  basic_shit_cpu_ocimem_ram #(
    .ADDR_W (ADDR_W),
    .LANE_W (LANE_W)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_ramWe & ~reset),
    .i_re    (w_ramRe),
    .i_addr  (w_ramAddr),
    .i_wdata (w_ramWide),
    .i_be    (w_ramBe),
    .o_rdata (w_ramRaw)
  );

  assign bus.readdata      = w_ramData;
  assign bus.waitrequest   = w_wait & ~reset;
  assign bus.MonDReg       = r_monDReg;
  assign bus.monitor_ready = r_ready;
  assign bus.monitor_error = r_error;

endmodule

// File: tb/tb_basic_shit_cpu_jtag_ocimem.sv
// Scoreboard bench: random JTAG/CPU traffic against an array model of the monitor RAM.
// With OCIMEM_PARITY_EN defined it also corrupts a stored parity bit.
module tb_basic_shit_cpu_jtag_ocimem;

  logic clk;
  logic reset;

  basic_shit_cpu_jtag_ocimem_if #(.ADDR_W(8)) bus ();

  basic_shit_cpu_jtag_ocimem #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] modelMem [256];
  logic [7:0]  modelAReg;
  logic        modelErr;
  logic [31:0] cpuExp[$];
  logic [31:0] jtagExp[$];
  int          nChecks = 0;
  int          nFails  = 0;
  logic        prevReady = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic sa, input logic sb, input logic sn, input logic [37:0] j,
                               input logic rd, input logic wr, input logic [7:0] ad,
                               input logic [31:0] wd, input logic [3:0] be, input logic dbg);
    bus.take_action_ocimem_a    = sa;
    bus.take_action_ocimem_b    = sb;
    bus.take_no_action_ocimem_a = sn;
    bus.jdo                     = j;
    bus.read                    = rd;
    bus.write                   = wr;
    bus.address                 = ad;
    bus.writedata               = wd;
    bus.byteenable              = be;
    bus.debugaccess             = dbg;
  endtask

  task automatic idleInputs();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] mkJdoA(input logic [7:0] ad, input logic rd, input logic clr);
    logic [37:0] j;
    j = 38'({$urandom(), $urandom()});
    j[35] = rd;
    j[33:26] = ad;
    j[25] = clr;
    return j;
  endfunction

  function automatic logic [37:0] mkJdoB(input logic [31:0] d);
    logic [37:0] j;
    j = 38'({$urandom(), $urandom()});
    j[34:3] = d;
    return j;
  endfunction

  task automatic waitReady(input string name, input int expCnt);
    int cnt = 0;
    while (!bus.monitor_ready && cnt < 20) begin
      tick();
      cnt++;
    end
    checkOutput(name, 32'(cnt), 32'(expCnt));
  endtask

  task automatic jtagA(input logic [7:0] ad, input logic rd, input logic clr);
    applyStimulus(1'b1, 1'b0, 1'b0, mkJdoA(ad, rd, clr), 1'b0, 1'b0, '0, '0, '0, 1'b0);
    modelAReg = ad;
    if (clr) modelErr = 1'b0;
    if (rd) jtagExp.push_back(modelMem[ad]);
    tick();
    idleInputs();
    if (rd) waitReady("jtagReadLatency", 2);
  endtask

  task automatic jtagN();
    applyStimulus(1'b0, 1'b0, 1'b1, 38'({$urandom(), $urandom()}), 1'b0, 1'b0, '0, '0, '0, 1'b0);
    jtagExp.push_back(modelMem[modelAReg]);
    modelAReg = modelAReg + 8'd1;
    tick();
    idleInputs();
    waitReady("streamReadLatency", 2);
  endtask

  task automatic jtagB(input logic [31:0] d);
    applyStimulus(1'b0, 1'b1, 1'b0, mkJdoB(d), 1'b0, 1'b0, '0, '0, '0, 1'b0);
    modelMem[modelAReg] = d;
    modelAReg = modelAReg + 8'd1;
    tick();
    idleInputs();
    tick();
  endtask

  task automatic cpuWrite(input logic [7:0] ad, input logic [31:0] wd, input logic [3:0] be, input logic dbg);
    int cnt = 0;
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, ad, wd, be, dbg);
    @(negedge clk);
    while (bus.waitrequest && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    if (cnt >= 20) checkOutput("cpuWriteTimeout", 32'(cnt), 32'd0);
    @(posedge clk);
    #1;
    idleInputs();
    if (dbg) begin
      for (int i = 0; i < 4; i++) if (be[i]) modelMem[ad][i*8 +: 8] = wd[i*8 +: 8];
    end else begin
      modelErr = 1'b1;
    end
  endtask

  task automatic cpuRead(input logic [7:0] ad, output int waits);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, ad, '0, '0, 1'b0);
    cpuExp.push_back(modelMem[ad]);
    waits = 0;
    @(negedge clk);
    while (bus.waitrequest && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    if (waits >= 20) checkOutput("cpuReadTimeout", 32'(waits), 32'd0);
    @(posedge clk);
    #1;
    idleInputs();
  endtask

  // Monitor: scores CPU reads on completion and MonDReg on each rising monitor_ready.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        prevReady = 1'b0;
      end else begin
        if (bus.read && !bus.waitrequest) begin
          if (cpuExp.size() == 0) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL cpuUnexpected: got readdata %h with no read outstanding", bus.readdata);
          end else begin
            checkOutput("cpuReaddata", bus.readdata, cpuExp.pop_front());
          end
        end
        if (bus.monitor_ready && !prevReady) begin
          if (jtagExp.size() == 0) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL jtagUnexpected: got MonDReg %h with no read outstanding", bus.MonDReg);
          end else begin
            checkOutput("jtagMonDReg", bus.MonDReg, jtagExp.pop_front());
          end
        end
        prevReady = bus.monitor_ready;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          waits;
    logic [31:0] d;
    logic [31:0] oldVal;
    reset = 1'b1;
    idleInputs();
    modelAReg = '0;
    modelErr  = 1'b0;
    repeat (3) tick();
    checkOutput("resetMonDReg", bus.MonDReg, 32'd0);
    checkOutput("resetReady", 32'(bus.monitor_ready), 32'd0);
    checkOutput("resetError", 32'(bus.monitor_error), 32'd0);
    checkOutput("resetReaddata", bus.readdata, 32'd0);
    checkOutput("resetWait", 32'(bus.waitrequest), 32'd0);
    reset = 1'b0;
    tick();

    for (int a = 0; a < 256; a++) cpuWrite(8'(a), $urandom(), 4'hF, 1'b1);

    $display("[TB] directed JTAG write/read");
    jtagA(8'h10, 1'b0, 1'b0);
    jtagB(32'hDEADBEEF);
    jtagN();
    jtagA(8'h10, 1'b1, 1'b0);
    checkOutput("monDRegDeadbeef", bus.MonDReg, 32'hDEADBEEF);

    $display("[TB] address wrap");
    jtagA(8'hFF, 1'b0, 1'b0);
    jtagN();
    jtagN();

    $display("[TB] CPU byte-enable write and permission");
    cpuWrite(8'h20, 32'hFFFFFFFF, 4'hF, 1'b1);
    cpuWrite(8'h20, 32'h12345678, 4'b0011, 1'b1);
    cpuRead(8'h20, waits);
    checkOutput("cpuReadWaits", 32'(waits), 32'd1);
    cpuWrite(8'h20, 32'hAAAAAAAA, 4'hF, 1'b0);
    checkOutput("errAfterNoDebug", 32'(bus.monitor_error), 32'(modelErr));
    cpuRead(8'h20, waits);
    jtagA(8'h20, 1'b0, 1'b1);
    checkOutput("errCleared", 32'(bus.monitor_error), 32'(modelErr));

    $display("[TB] CPU read colliding with JTAG write");
    jtagA(8'h30, 1'b0, 1'b0);
    d = $urandom();
    modelMem[8'h30] = d;
    modelAReg = 8'h31;
    cpuExp.push_back(d);
    applyStimulus(1'b0, 1'b1, 1'b0, mkJdoB(d), 1'b1, 1'b0, 8'h30, '0, '0, 1'b0);
    @(negedge clk);
    waits = bus.waitrequest ? 1 : 0;
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 8'h30, '0, '0, 1'b0);
    @(negedge clk);
    while (bus.waitrequest && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    idleInputs();
    checkOutput("collisionStalled", 32'(waits >= 2), 32'd1);
    jtagN();

    $display("[TB] strobe dropped while busy");
    applyStimulus(1'b1, 1'b0, 1'b0, mkJdoA(8'h50, 1'b1, 1'b0), 1'b0, 1'b0, '0, '0, '0, 1'b0);
    modelAReg = 8'h50;
    jtagExp.push_back(modelMem[8'h50]);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    modelErr = 1'b1;
    tick();
    idleInputs();
    waitReady("busyReadLatency", 1);
    checkOutput("errDroppedStrobe", 32'(bus.monitor_error), 32'(modelErr));
    jtagN();

    $display("[TB] simultaneous strobes");
    jtagA(8'h60, 1'b0, 1'b1);
    d = $urandom() | 32'h0040_0000;
    applyStimulus(1'b1, 1'b1, 1'b0, mkJdoB(d), 1'b0, 1'b0, '0, '0, '0, 1'b0);
    modelMem[modelAReg] = d;
    modelAReg = modelAReg + 8'd1;
    modelErr = 1'b1;
    tick();
    idleInputs();
    tick();
    checkOutput("errMultiStrobe", 32'(bus.monitor_error), 32'(modelErr));
    jtagA(8'h60, 1'b1, 1'b0);

    $display("[TB] random traffic");
    for (int it = 0; it < 200; it++) begin
      case ($urandom_range(0, 4))
        0: cpuWrite(8'($urandom()), $urandom(), 4'($urandom()), $urandom_range(0, 7) != 0);
        1: cpuRead(8'($urandom()), waits);
        2: jtagA(8'($urandom()), 1'($urandom()), $urandom_range(0, 3) == 0);
        3: jtagB($urandom());
        default: jtagN();
      endcase
      checkOutput("randomErrFlag", 32'(bus.monitor_error), 32'(modelErr));
    end

    $display("[TB] reset during JTAG write");
    jtagA(8'h40, 1'b0, 1'b0);
    oldVal = modelMem[8'h40];
    applyStimulus(1'b0, 1'b1, 1'b0, mkJdoB(~oldVal), 1'b0, 1'b0, '0, '0, '0, 1'b0);
    tick();
    reset = 1'b1;
    idleInputs();
    tick();
    tick();
    reset = 1'b0;
    modelAReg = '0;
    modelErr  = 1'b0;
    checkOutput("rstMonDReg", bus.MonDReg, 32'd0);
    checkOutput("rstReady", 32'(bus.monitor_ready), 32'd0);
    checkOutput("rstError", 32'(bus.monitor_error), 32'd0);
    checkOutput("rstReaddata", bus.readdata, 32'd0);
    checkOutput("rstWait", 32'(bus.waitrequest), 32'd0);
    jtagN();
    jtagA(8'h40, 1'b1, 1'b0);

`ifdef OCIMEM_PARITY_EN
    $display("[TB] parity corruption");
    dut.u_ram.r_mem[5][8] = ~dut.u_ram.r_mem[5][8];
    cpuRead(8'd5, waits);
    modelErr = 1'b1;
    checkOutput("parityErr", 32'(bus.monitor_error), 32'(modelErr));
`endif

    repeat (3) tick();
    checkOutput("cpuQueueDrained", 32'(cpuExp.size()), 32'd0);
    checkOutput("jtagQueueDrained", 32'(jtagExp.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
